// File: rtl/ctrl_prog_mem.sv
// Program store feeding the controller: streamed load of instruction words,
// then registered fetch by pc with out-of-range detection.
module ctrl_prog_mem #(
  parameter int INSTR_WIDTH      = 31,
  parameter int INSTR_ADDR_WIDTH = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        prog_i,
  input  logic                        load_valid_i,
  input  logic [INSTR_WIDTH-1:0]      load_data_i,
  input  logic                        load_last_i,
  output logic                        load_ready_o,
  input  logic                        fetch_i,
  input  logic [INSTR_ADDR_WIDTH-1:0] pc_i,
  output logic [INSTR_WIDTH-1:0]      instr_word_o,
  output logic                        instr_valid_o,
  output logic [INSTR_ADDR_WIDTH:0]   prog_len_o,
  output logic                        prog_done_o,
  output logic                        pc_err_o
);
  localparam int AW = INSTR_ADDR_WIDTH;
  localparam int PROG_SIZE = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LEN_ONE   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]            prog_len_q, prog_len_d;
  logic                   prog_done_q, prog_done_d;
  logic                   pc_err_q, pc_err_d;
  logic [INSTR_WIDTH-1:0] instr_word_q, instr_word_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   mem_we;
  logic [INSTR_WIDTH-1:0] mem [PROG_SIZE];

  assign load_ready_o = (state_q == LOAD) & prog_i;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    prog_len_d    = prog_len_q;
    prog_done_d   = prog_done_q;
    pc_err_d      = pc_err_q;
    instr_word_d  = instr_word_q;
    instr_valid_d = 1'b0;
    mem_we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (prog_i) begin
          state_d     = LOAD;
          wr_ptr_d    = '0;
          prog_len_d  = '0;
          prog_done_d = 1'b0;
          pc_err_d    = 1'b0;
        end
      end
      LOAD: begin
        if (!prog_i) begin
          state_d     = IDLE;
          prog_len_d  = '0;
          prog_done_d = 1'b0;
        end else if (load_valid_i) begin
          mem_we = 1'b1;
          // Last slot forces completion so wr_ptr can never wrap.
          if (load_last_i || wr_ptr_q == LAST_ADDR) begin
            state_d     = RUN;
            prog_len_d  = {1'b0, wr_ptr_q} + LEN_ONE;
            prog_done_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
        end
      end
      RUN: begin
        // A reload request takes priority over a same-cycle fetch.
        if (prog_i) begin
          state_d     = LOAD;
          wr_ptr_d    = '0;
          prog_len_d  = '0;
          prog_done_d = 1'b0;
          pc_err_d    = 1'b0;
        end else if (fetch_i) begin
          instr_valid_d = 1'b1;
          if ({1'b0, pc_i} < prog_len_q) begin
            instr_word_d = mem[pc_i];
          end else begin
            instr_word_d = '0;
            pc_err_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      prog_done_q   <= 1'b0;
      pc_err_q      <= 1'b0;
      instr_word_q  <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      prog_len_q    <= prog_len_d;
      prog_done_q   <= prog_done_d;
      pc_err_q      <= pc_err_d;
      instr_word_q  <= instr_word_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Storage is deliberately not reset; prog_len gates what is readable.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wr_ptr_q] <= load_data_i;
  end

  assign instr_word_o  = instr_word_q;
  assign instr_valid_o = instr_valid_q;
  assign prog_len_o    = prog_len_q;
  assign prog_done_o   = prog_done_q;
  assign pc_err_o      = pc_err_q;
endmodule

// File: tb/tb_ctrl_prog_mem.sv
// Scoreboard bench for ctrl_prog_mem: fetches push expected words into a queue,
// a negedge monitor pops one per instr_valid pulse.
module tb_ctrl_prog_mem;
  localparam int IW = 31;
  localparam int AW = 5;
  localparam int PSIZE = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog = 1'b0, load_valid = 1'b0, load_last = 1'b0, fetch = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic [AW-1:0] pc = '0;
  logic          load_ready, instr_valid, prog_done, pc_err;
  logic [IW-1:0] instr_word;
  logic [AW:0]   prog_len;

  ctrl_prog_mem #(.INSTR_WIDTH(IW), .INSTR_ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .prog_i(prog), .load_valid_i(load_valid),
    .load_data_i(load_data), .load_last_i(load_last), .load_ready_o(load_ready),
    .fetch_i(fetch), .pc_i(pc), .instr_word_o(instr_word), .instr_valid_o(instr_valid),
    .prog_len_o(prog_len), .prog_done_o(prog_done), .pc_err_o(pc_err)
  );

  always #5 clk = ~clk;

  // Reference model: program contents, length, flags, last delivered word.
  logic [IW-1:0] model_mem [PSIZE];
  int            model_len  = 0;
  bit            model_done = 0, model_err = 0, model_run = 0;
  logic [IW-1:0] model_word = '0;
  logic [IW-1:0] exp_q [$];

  int checks = 0, passed = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && instr_valid) begin
      if (exp_q.size() == 0) chk("unexpected_instr_valid", 64'(instr_valid), 64'(0));
      else chk("instr_word", 64'(instr_word), 64'(exp_q.pop_front()));
    end
  end

  task automatic do_load(int n, bit use_last);
    logic [IW-1:0] d;
    prog = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      d = IW'($urandom);
      load_valid = 1'b1; load_data = d; load_last = use_last && (i == n - 1);
      @(negedge clk) chk("load_ready_in_load", 64'(load_ready), 64'(1));
      @(posedge clk); #1;
      model_mem[i] = d;
    end
    load_valid = 1'b0; load_last = 1'b0; fetch = 1'b0;
    model_len = n; model_done = 1; model_err = 0; model_run = 1;
    @(negedge clk);
    chk("load_ready_after", 64'(load_ready), 64'(0));
    chk("prog_len", 64'(prog_len), 64'(model_len));
    chk("prog_done", 64'(prog_done), 64'(model_done));
    chk("pc_err_cleared", 64'(pc_err), 64'(model_err));
    prog = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_abort(int n);
    prog = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1; load_data = IW'($urandom); load_last = 1'b0;
      @(posedge clk); #1;
    end
    load_valid = 1'b0; prog = 1'b0;
    @(posedge clk); #1;
    model_len = 0; model_done = 0; model_err = 0; model_run = 0;
    @(negedge clk);
    chk("abort_prog_len", 64'(prog_len), 64'(0));
    chk("abort_prog_done", 64'(prog_done), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_fetch(int p);
    fetch = 1'b1; pc = AW'(p);
    if (model_run && !prog) begin
      if (p < model_len) model_word = model_mem[p];
      else begin model_word = '0; model_err = 1; end
      exp_q.push_back(model_word);
    end
    @(posedge clk); #1;
  endtask

  task automatic end_fetch();
    fetch = 1'b0;
    @(negedge clk);
    chk("pc_err", 64'(pc_err), 64'(model_err));
    chk("instr_word_hold", 64'(instr_word), 64'(model_word));
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held while inputs toggle: every output stays 0.
    for (int c = 0; c < 4; c++) begin
      prog = 1'($urandom); load_valid = 1'($urandom); load_last = 1'($urandom);
      fetch = 1'($urandom); pc = AW'($urandom); load_data = IW'($urandom);
      @(negedge clk);
      chk("reset_outputs", 64'({load_ready, instr_valid, prog_done, pc_err, prog_len, instr_word}), 64'(0));
    end
    prog = 0; load_valid = 0; load_last = 0; fetch = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Three words, back-to-back fetches.
    do_load(3, 1);
    for (int p = 0; p < 3; p++) do_fetch(p);
    end_fetch();

    // Full memory, no last marker: forced completion.
    do_load(32, 0);
    load_valid = 1'b1;  // ignored in RUN
    do_fetch(31); do_fetch(0);
    load_valid = 1'b0;
    end_fetch();
    chk("full_len_hold", 64'(prog_len), 64'(32));

    // Out-of-range fetch sets sticky error; a later valid fetch keeps it.
    do_load(3, 1);
    do_fetch(5); do_fetch(1);
    end_fetch();
    do_fetch(2);
    end_fetch();

    // Reload with fetch asserted in RUN and during LOAD: never served; clears error.
    fetch = 1'b1; pc = '0;
    do_load(4, 1);
    do_fetch(3);
    end_fetch();

    // Abort after 2 of 4 words; fetch afterwards is not served.
    do_abort(2);
    do_fetch(0); do_fetch(1);
    end_fetch();

    // Async reset mid-LOAD.
    prog = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b1; load_data = IW'($urandom);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 64'({load_ready, instr_valid, prog_done, pc_err, prog_len, instr_word}), 64'(0));
    model_run = 0; model_len = 0; model_done = 0; model_err = 0; model_word = '0;
    load_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    do_load(3, 1);
    for (int p = 0; p < 3; p++) do_fetch(p);
    end_fetch();

    // Randomised programs and fetch addresses.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 32);
      do_load(n, (n < 32) ? 1'b1 : 1'($urandom));
      for (int k = 0; k < 6; k++) do_fetch($urandom_range(0, 31));
      end_fetch();
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
